mod_counter: RTL and testbench

//   Parametrised up/down modulo counter. Successor to the fixed 8-bit enable counter.

---
 rtl/mod_counter_pkg.sv | 23 ++
 rtl/mod_counter_prescaler.sv | 34 +++
 rtl/mod_counter.sv | 111 +++++++++++
 tb/tb_mod_counter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// counter_pkg: shared types and helpers for the modulo counter family.
//   cnt_mode_e   : CNT_WRAP (0) wraps around at the range ends,
//                  CNT_SAT  (1) holds at the range ends.
//   CNT_MAX_WIDTH: widest count supported by the shared clamp helper.
//   clamp_u      : unsigned min(value, bound), shared with timing blocks.
package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  localparam int unsigned CNT_MAX_WIDTH = 32;

  // Callers zero-extend their operands to CNT_MAX_WIDTH and truncate the result.
  function automatic logic [CNT_MAX_WIDTH-1:0] clamp_u(
    input logic [CNT_MAX_WIDTH-1:0] value,
    input logic [CNT_MAX_WIDTH-1:0] bound
  );
    return (value > bound) ? bound : value;
  endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// counter_prescaler: divide-by-PRESCALE step qualifier for mod_counter.
//   clk      in  clock, rising edge
//   aresetn  in  asynchronous active-low reset (phase -> 0)
//   enable   in  advance the phase this cycle
//   restart  in  synchronous return of the phase to 0 (wins over enable)
//   tick     out combinational; high on the enabled cycle where phase==PRESCALE-1
module counter_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic aresetn,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  assign tick = enable && (phase == LAST);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      phase <= '0;
    end else if (restart) begin
      phase <= '0;
    end else if (enable) begin
      phase <= tick ? '0 : phase + PW'(1);
    end
  end

endmodule

// File: rtl/mod_counter.sv
// mod_counter: parametrised up/down modulo counter with runtime limit.
//   Parameters: WIDTH (1..32), RESET_VALUE (<= 2**WIDTH-1),
//               PRESCALE (>=1, only used when MOD_COUNTER_PRESCALE_EN is defined).
//   clk        in  clock, rising edge
//   aresetn    in  asynchronous active-low reset: count=RESET_VALUE, wrapped=0
//   enable     in  count one step this cycle
//   clear      in  synchronous clear to 0 (highest priority)
//   load       in  synchronous load of min(load_value, limit)
//   load_value in  value for load
//   up         in  1 = count up, 0 = count down
//   mode       in  CNT_WRAP / CNT_SAT behaviour at the range ends
//   limit      in  inclusive upper bound, range is 0..limit
//   count      out registered count
//   tc         out combinational terminal count
//   wrapped    out registered pulse, high while count shows a wrapped value
// Build option: define MOD_COUNTER_PRESCALE_EN to gate steps through a
// divide-by-PRESCALE prescaler; otherwise every enabled cycle steps.
module mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned RESET_VALUE = 0,
  parameter int unsigned PRESCALE    = 4
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up,
  input  cnt_mode_e        mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped
);

  if (WIDTH < 1 || WIDTH > CNT_MAX_WIDTH || PRESCALE < 1) begin : g_bad_params
    $error("mod_counter: WIDTH must be 1..32 and PRESCALE >= 1");
  end

  localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VALUE);

  logic             step_ok;
  logic             step;
  logic             at_top;
  logic             at_zero;
  logic [WIDTH-1:0] count_next;
  logic             wrapped_next;

`ifdef MOD_COUNTER_PRESCALE_EN
  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .aresetn(aresetn),
    .enable (enable),
    .restart(clear || load),
    .tick   (step_ok)
  );
`else
  assign step_ok = 1'b1;
`endif

  assign step = enable && step_ok;

  always_comb begin
    count_next   = count;
    wrapped_next = 1'b0;
    at_top       = (count >= limit);
    at_zero      = (count == '0);
    tc           = (up && at_top) || (!up && at_zero);

    if (clear) begin
      count_next = '0;
    end else if (load) begin
      count_next = WIDTH'(clamp_u(CNT_MAX_WIDTH'(load_value), CNT_MAX_WIDTH'(limit)));
    end else if (step) begin
      if (up) begin
        if (!at_top) begin
          count_next = count + WIDTH'(1);
        end else if (mode == CNT_WRAP) begin
          count_next   = '0;
          wrapped_next = 1'b1;
        end else begin
          // Saturation also pulls the count down if limit was lowered below it.
          count_next = limit;
        end
      end else begin
        if (!at_zero) begin
          count_next = (count > limit) ? limit : count - WIDTH'(1);
        end else if (mode == CNT_WRAP) begin
          count_next   = limit;
          wrapped_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      count   <= RESET_COUNT;
      wrapped <= 1'b0;
    end else begin
      count   <= count_next;
      wrapped <= wrapped_next;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
module tb_mod_counter;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       enable;
  logic       clear;
  logic       load;
  logic [7:0] load_value;
  logic       up;
  cnt_mode_e  mode;
  logic [7:0] limit;
  logic [7:0] count;
  logic       tc;
  logic       wrapped;

  int errors = 0;
  int checks = 0;

  logic [7:0] q_count[$];
  logic       q_wrap[$];
  logic       q_tc[$];

  always #5 clk = ~clk;

  mod_counter #(
    .WIDTH(8),
    .RESET_VALUE(2),
    .PRESCALE(4)
  ) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .enable    (enable),
    .clear     (clear),
    .load      (load),
    .load_value(load_value),
    .up        (up),
    .mode      (mode),
    .limit     (limit),
    .count     (count),
    .tc        (tc),
    .wrapped   (wrapped)
  );

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] c, input logic w, input logic t);
    q_count.push_back(c);
    q_wrap.push_back(w);
    q_tc.push_back(t);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (count !== 8'd2) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 2", count);
    end
    checks++;
    if (wrapped !== 1'b0) begin
      errors++;
      $display("FAIL reset_wrapped: got %b expected 0", wrapped);
    end
    @(negedge clk);
    aresetn = 1'b1;
    tick_clk();
    checks++;
    if (count !== 8'd2) begin
      errors++;
      $display("FAIL reset_hold: got %0d expected 2", count);
    end
  endtask

  task automatic test_enable_wrap();
    logic [7:0] ec[8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1, 8'd2};
    logic       ew[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       et[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    limit = 8'd5; mode = CNT_WRAP; up = 1'b1;
    clear = 1'b1;
    tick_clk();
    clear = 1'b0;
    checks++;
    if (count !== 8'd0) begin
      errors++;
      $display("FAIL wrap_clear: got %0d expected 0", count);
    end
    for (int i = 0; i < 8; i++) push_exp(ec[i], ew[i], et[i]);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] c; logic w; logic t;
      tick_clk();
      c = q_count.pop_front(); w = q_wrap.pop_front(); t = q_tc.pop_front();
      checks++;
      if (count !== c || wrapped !== w || tc !== t) begin
        errors++;
        $display("FAIL wrap_step[%0d]: got count=%0d wrapped=%b tc=%b expected count=%0d wrapped=%b tc=%b",
                 i, count, wrapped, tc, c, w, t);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_saturate();
    logic [7:0] ec[11] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
    logic       et[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    limit = 8'd3; mode = CNT_SAT; up = 1'b1;
    clear = 1'b1;
    tick_clk();
    clear = 1'b0;
    for (int i = 0; i < 11; i++) push_exp(ec[i], 1'b0, et[i]);
    enable = 1'b1;
    for (int i = 0; i < 11; i++) begin
      logic [7:0] c; logic w; logic t;
      up = (i < 6);
      tick_clk();
      c = q_count.pop_front(); w = q_wrap.pop_front(); t = q_tc.pop_front();
      checks++;
      if (count !== c || wrapped !== w || tc !== t) begin
        errors++;
        $display("FAIL sat_step[%0d]: got count=%0d wrapped=%b tc=%b expected count=%0d wrapped=%b tc=%b",
                 i, count, wrapped, tc, c, w, t);
      end
    end
    enable = 1'b0; up = 1'b1;
  endtask

  task automatic test_priority();
    mode = CNT_WRAP; up = 1'b1; limit = 8'd10;
    push_exp(8'd4, 1'b0, 1'b0);
    push_exp(8'd0, 1'b0, 1'b0);
    push_exp(8'd7, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] c; logic w; logic t;
      case (i)
        0: begin load = 1'b1; load_value = 8'd4; end
        1: begin clear = 1'b1; load = 1'b1; load_value = 8'd9; enable = 1'b1; end
        default: begin clear = 1'b0; enable = 1'b0; load = 1'b1; load_value = 8'd9; limit = 8'd7; end
      endcase
      tick_clk();
      c = q_count.pop_front(); w = q_wrap.pop_front(); t = q_tc.pop_front();
      checks++;
      if (count !== c || wrapped !== w || tc !== t) begin
        errors++;
        $display("FAIL priority[%0d]: got count=%0d wrapped=%b tc=%b expected count=%0d wrapped=%b tc=%b",
                 i, count, wrapped, tc, c, w, t);
      end
    end
    load = 1'b0; clear = 1'b0; enable = 1'b0;
  endtask

  task automatic test_down_wrap();
    mode = CNT_WRAP; limit = 8'd5; up = 1'b1;
    load = 1'b1; load_value = 8'd1;
    tick_clk();
    load = 1'b0;
    push_exp(8'd0, 1'b0, 1'b1);
    push_exp(8'd5, 1'b1, 1'b0);
    push_exp(8'd0, 1'b1, 1'b0);
    push_exp(8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] c; logic w; logic t;
      case (i)
        0, 1: begin up = 1'b0; enable = 1'b1; end
        2: begin up = 1'b1; limit = 8'd2; enable = 1'b1; end
        default: enable = 1'b0;
      endcase
      tick_clk();
      c = q_count.pop_front(); w = q_wrap.pop_front(); t = q_tc.pop_front();
      checks++;
      if (count !== c || wrapped !== w || tc !== t) begin
        errors++;
        $display("FAIL down_wrap[%0d]: got count=%0d wrapped=%b tc=%b expected count=%0d wrapped=%b tc=%b",
                 i, count, wrapped, tc, c, w, t);
      end
    end
  endtask

  task automatic test_async_reset();
    mode = CNT_WRAP; up = 1'b1; limit = 8'd10;
    load = 1'b1; load_value = 8'd3;
    tick_clk();
    load = 1'b0; enable = 1'b1;
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if (count !== 8'd2 || wrapped !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got count=%0d wrapped=%b expected count=2 wrapped=0", count, wrapped);
    end
    @(negedge clk);
    aresetn = 1'b1;
    tick_clk();
    checks++;
    if (count !== 8'd3) begin
      errors++;
      $display("FAIL resume_after_reset: got %0d expected 3", count);
    end
    enable = 1'b0;
    limit = 8'hFF;
    push_exp(8'hFF, 1'b0, 1'b1);
    push_exp(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      logic [7:0] c; logic w; logic t;
      load = (i == 0); load_value = 8'hFF; enable = (i == 1);
      tick_clk();
      c = q_count.pop_front(); w = q_wrap.pop_front(); t = q_tc.pop_front();
      checks++;
      if (count !== c || wrapped !== w || tc !== t) begin
        errors++;
        $display("FAIL full_range[%0d]: got count=%0h wrapped=%b tc=%b expected count=%0h wrapped=%b tc=%b",
                 i, count, wrapped, tc, c, w, t);
      end
    end
    load = 1'b0; enable = 1'b0;
  endtask

  task automatic test_limit_zero();
    limit = 8'd0; mode = CNT_WRAP; up = 1'b1;
    load = 1'b1; load_value = 8'd9;
    tick_clk();
    load = 1'b0;
    checks++;
    if (count !== 8'd0 || tc !== 1'b1) begin
      errors++;
      $display("FAIL zero_limit_load: got count=%0d tc=%b expected count=0 tc=1", count, tc);
    end
    up = 1'b0;
    #1;
    checks++;
    if (tc !== 1'b1) begin
      errors++;
      $display("FAIL zero_limit_tc_down: got %b expected 1", tc);
    end
    push_exp(8'd0, 1'b1, 1'b1);
    push_exp(8'd0, 1'b1, 1'b1);
    push_exp(8'd0, 1'b0, 1'b1);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] c; logic w; logic t;
      up = (i != 1);
      mode = (i == 2) ? CNT_SAT : CNT_WRAP;
      tick_clk();
      c = q_count.pop_front(); w = q_wrap.pop_front(); t = q_tc.pop_front();
      checks++;
      if (count !== c || wrapped !== w || tc !== t) begin
        errors++;
        $display("FAIL zero_limit_step[%0d]: got count=%0d wrapped=%b tc=%b expected count=%0d wrapped=%b tc=%b",
                 i, count, wrapped, tc, c, w, t);
      end
    end
    enable = 1'b0; up = 1'b1; mode = CNT_WRAP;
  endtask

`ifdef MOD_COUNTER_PRESCALE_EN
  task automatic test_prescale();
    logic [7:0] ec[18] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3,
                           8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd4};
    logic       en[18] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                           1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    limit = 8'd100; mode = CNT_WRAP; up = 1'b1;
    clear = 1'b1;
    tick_clk();
    clear = 1'b0;
    for (int i = 0; i < 18; i++) push_exp(ec[i], 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      logic [7:0] c; logic w; logic t;
      enable = en[i];
      tick_clk();
      c = q_count.pop_front(); w = q_wrap.pop_front(); t = q_tc.pop_front();
      checks++;
      if (count !== c || wrapped !== w || tc !== t) begin
        errors++;
        $display("FAIL prescale[%0d]: got count=%0d wrapped=%b tc=%b expected count=%0d wrapped=%b tc=%b",
                 i, count, wrapped, tc, c, w, t);
      end
    end
    enable = 1'b0;
  endtask
`endif

  initial begin
    aresetn = 1'b0; enable = 1'b0; clear = 1'b0; load = 1'b0;
    load_value = '0; up = 1'b1; mode = CNT_WRAP; limit = '0;
    test_reset();
    test_priority();
`ifdef MOD_COUNTER_PRESCALE_EN
    test_prescale();
`else
    test_enable_wrap();
    test_saturate();
    test_down_wrap();
    test_async_reset();
    test_limit_zero();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
